painterengine_gpu_scanout: RTL and testbench
============================================

PAINTERENGINE_GPU_SCANOUT -- requirements
Module: painterengine_gpu_scanout

Interface
REQ-001 SHALL have parameter PARAM_DATA_WIDTH, default 32, pixel/memory word width.
REQ-002 SHALL have parameter PARAM_FIFO_DEPTH, default 64, pixel FIFO entries (power of two, >= 2*PARAM_BURST_LEN).
REQ-003 SHALL have parameter PARAM_BURST_LEN, default 16, maximum beats per memory read request.
REQ-004 SHALL have ports: i_wire_pixel_clock in 1 clock; i_wire_reset in 1 reset. One clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: i_wire_start in 1 frame start pulse; i_wire_base_addr in 32 frame byte address; i_wire_clip_width in 16; i_wire_clip_height in 16.
REQ-006 SHALL have ports: o_wire_rd_req out 1; o_wire_rd_addr out 32; o_wire_rd_len out 8 (beats); i_wire_rd_ack in 1; i_wire_rd_valid in 1; i_wire_rd_data in PARAM_DATA_WIDTH.
REQ-007 SHALL have ports: i_wire_next_rgb in 1 (pixel consumed); o_wire_rgba out 32; o_wire_dvi_resetn out 1; i_wire_dvi_done in 1.
REQ-008 SHALL have ports: o_wire_busy out 1; o_wire_frame_done out 1 (pulse); o_wire_underflow out 1 (sticky).

Function
REQ-009 SHALL implement FSM IDLE, FETCH, WAIT_DATA, DRAIN, DONE.
REQ-010 IDLE: i_wire_start latches base, width, height and total = width*height (32-bit unsigned); total==0 -> DONE, else FETCH; start outside IDLE SHALL be ignored.
REQ-011 FETCH: SHALL assert o_wire_rd_req only when FIFO free space >= len, len = min(PARAM_BURST_LEN, remaining).
REQ-012 o_wire_rd_req/addr/len SHALL hold stable until the cycle i_wire_rd_ack is high; that cycle -> WAIT_DATA, addr += 4*len, remaining -= len.
REQ-013 WAIT_DATA: each i_wire_rd_valid beat SHALL be pushed to the FIFO; after len beats -> FETCH if remaining>0, else DRAIN; rd_valid outside WAIT_DATA SHALL be dropped.
REQ-014 FIFO SHALL be first-word-fall-through: o_wire_rgba = head entry, 32'h0 when empty; i_wire_next_rgb pops head in the same cycle.
REQ-015 Simultaneous push and pop SHALL both take effect; count unchanged; push never overflows (guaranteed by REQ-011).
REQ-016 i_wire_next_rgb with FIFO empty SHALL set o_wire_underflow (sticky until reset or next accepted start) and pop nothing.
REQ-017 o_wire_dvi_resetn SHALL rise one cycle after FIFO count >= PARAM_BURST_LEN or remaining==0 with FIFO non-empty, and stay high until DONE.
REQ-018 DRAIN: SHALL wait for i_wire_dvi_done high -> DONE.
REQ-019 DONE: o_wire_frame_done high exactly one cycle, o_wire_dvi_resetn low, FIFO flushed, next state IDLE.
REQ-020 o_wire_busy SHALL be high in every state except IDLE.

Reset
REQ-021 i_wire_reset high at a clock edge SHALL force IDLE, empty FIFO, remaining=0, and all outputs 0 (o_wire_dvi_resetn 0), including mid-burst; beats arriving after reset SHALL be dropped.

Configuration
REQ-022 With SCANOUT_UNDERFLOW_CNT_EN defined, SHALL add output o_wire_underflow_cnt (16 bits, saturating at 16'hFFFF) counting empty-FIFO pops, cleared with o_wire_underflow; without it, port and counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-023 Shared package painterengine_gpu_pkg SHALL hold FSM state encoding, display-mode and RGBA-mode constants, and the 4-byte pixel stride.
REQ-024 FIFO SHALL be sub-module painterengine_gpu_scanout_fifo (FWFT, push/pop/count/flush); FSM and address logic stay in top.

Verification
REQ-025 width=8, height=4, base=0x1000, ack/valid immediate -> requests (0x1000,16),(0x1040,16); 32 pixels popped in order; one frame_done pulse.
REQ-026 width=20, height=1 -> requests len 16 then len 4 at 0x1040; no further request.
REQ-027 width=0 -> DONE next cycle, frame_done pulse, no rd_req, dvi_resetn never high.
REQ-028 Hold rd_ack low 10 cycles -> rd_req/addr/len unchanged; next_rgb on empty FIFO -> underflow=1, rgba=0.
REQ-029 Reset asserted during second burst's 5th beat -> next cycle IDLE, busy=0, FIFO empty, remaining beats ignored.
REQ-030 Start pulsed while busy -> ignored; latched base/size unchanged through frame end.

Source files
------------

// File: rtl/painterengine_gpu_pkg.sv
// painterengine_gpu_pkg
// Shared definitions for the PainterEngine GPU display path:
//   - scanout FSM state encoding
//   - display-mode and RGBA-mode constants
//   - pixel stride in bytes (one 32-bit RGBA pixel per memory word)
//   - burst_len(): beats for the next memory read request
package painterengine_gpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
    } scanout_state_t;

    localparam logic [1:0] DISPLAY_MODE_OFF     = 2'd0;
    localparam logic [1:0] DISPLAY_MODE_DVI     = 2'd1;
    localparam logic [1:0] DISPLAY_MODE_LCD     = 2'd2;

    localparam logic [1:0] RGBA_MODE_RGBA8888   = 2'd0;
    localparam logic [1:0] RGBA_MODE_BGRA8888   = 2'd1;
    localparam logic [1:0] RGBA_MODE_ARGB8888   = 2'd2;

    localparam logic [31:0] PIXEL_STRIDE_BYTES  = 32'd4;

    // Beats for the next request: the full burst, or whatever is left of the frame.
    function automatic logic [7:0] burst_len(input logic [31:0] remaining,
                                             input logic [7:0]  max_len);
        logic [7:0] len;
        if (remaining < {24'd0, max_len}) begin
            len = remaining[7:0];
        end else begin
            len = max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/painterengine_gpu_scanout_fifo.sv
// painterengine_gpu_scanout_fifo
// First-word-fall-through pixel FIFO between memory read data and the display.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : empties the FIFO (end of frame)
//   push, push_data : write one entry (caller guarantees free space)
//   pop             : remove the head entry; ignored when empty
//   head_data       : current head entry, zero when empty
//   count, empty    : occupancy
module painterengine_gpu_scanout_fifo
    import painterengine_gpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CW-1:0]         count,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  pop_ok_s;

    assign pop_ok_s  = pop && (count_r != {CW{1'b0}});
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign head_data = empty ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push, pop_ok_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; a write racing a flush lands in a slot the reset pointers treat as free.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/painterengine_gpu_scanout.sv
// painterengine_gpu_scanout
// Streams one frame of RGBA pixels from memory to the display: issues burst
// read requests sized to the free FIFO space, buffers returned beats in a FWFT
// FIFO and hands pixels out on i_wire_next_rgb.
// Ports:
//   i_wire_pixel_clock, i_wire_reset      : clock, synchronous active-high reset
//   i_wire_start, i_wire_base_addr,
//   i_wire_clip_width, i_wire_clip_height : frame start and geometry (latched in IDLE)
//   o_wire_rd_req/addr/len, i_wire_rd_ack : read request handshake (len in beats)
//   i_wire_rd_valid, i_wire_rd_data       : read data beats
//   i_wire_next_rgb, o_wire_rgba          : pixel consume / head pixel (0 when empty)
//   o_wire_dvi_resetn, i_wire_dvi_done    : display enable / display finished
//   o_wire_busy, o_wire_frame_done,
//   o_wire_underflow                      : status (frame_done pulses, underflow sticky)
// Build option: define SCANOUT_UNDERFLOW_CNT_EN to add o_wire_underflow_cnt,
//   a saturating 16-bit count of pops attempted on an empty FIFO.
module painterengine_gpu_scanout
    import painterengine_gpu_pkg::*;
#(
    parameter int PARAM_DATA_WIDTH = 32,
    parameter int PARAM_FIFO_DEPTH = 64,
    parameter int PARAM_BURST_LEN  = 16
) (
    input  logic                        i_wire_pixel_clock,
    input  logic                        i_wire_reset,
    input  logic                        i_wire_start,
    input  logic [31:0]                 i_wire_base_addr,
    input  logic [15:0]                 i_wire_clip_width,
    input  logic [15:0]                 i_wire_clip_height,
    output logic                        o_wire_rd_req,
    output logic [31:0]                 o_wire_rd_addr,
    output logic [7:0]                  o_wire_rd_len,
    input  logic                        i_wire_rd_ack,
    input  logic                        i_wire_rd_valid,
    input  logic [PARAM_DATA_WIDTH-1:0] i_wire_rd_data,
    input  logic                        i_wire_next_rgb,
    output logic [31:0]                 o_wire_rgba,
    output logic                        o_wire_dvi_resetn,
    input  logic                        i_wire_dvi_done,
    output logic                        o_wire_busy,
    output logic                        o_wire_frame_done,
    output logic                        o_wire_underflow
`ifdef SCANOUT_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                 o_wire_underflow_cnt
`endif
);

    localparam int         CW      = $clog2(PARAM_FIFO_DEPTH) + 1;
    localparam logic [7:0] MAX_LEN = 8'(PARAM_BURST_LEN);

    scanout_state_t state_r;
    logic [31:0]    addr_r;
    logic [31:0]    remaining_r;
    logic [7:0]     beats_left_r;
    logic           rd_req_r;
    logic [31:0]    rd_addr_r;
    logic [7:0]     rd_len_r;
    logic           busy_r;
    logic           frame_done_r;
    logic           dvi_resetn_r;
    logic           underflow_r;

    logic [31:0]                 total_s;
    logic [7:0]                  len_s;
    logic [CW-1:0]               fifo_count_s;
    logic [CW-1:0]               free_s;
    logic                        fifo_empty_s;
    logic [PARAM_DATA_WIDTH-1:0] fifo_head_s;
    logic                        push_s;
    logic                        flush_s;
    logic                        dvi_cond_s;
    logic                        empty_pop_s;
    logic                        start_ok_s;

    assign total_s     = 32'(i_wire_clip_width) * 32'(i_wire_clip_height);
    assign len_s       = burst_len(remaining_r, MAX_LEN);
    assign free_s      = CW'(PARAM_FIFO_DEPTH) - fifo_count_s;
    assign push_s      = (state_r == ST_WAIT_DATA) && i_wire_rd_valid;
    assign flush_s     = (state_r == ST_DONE);
    assign empty_pop_s = i_wire_next_rgb && fifo_empty_s;
    assign start_ok_s  = (state_r == ST_IDLE) && i_wire_start;
    // Display may start once a full burst is buffered, or the tail of the frame is in.
    assign dvi_cond_s  = (32'(fifo_count_s) >= 32'(PARAM_BURST_LEN)) ||
                         ((remaining_r == 32'd0) && !fifo_empty_s);

    painterengine_gpu_scanout_fifo #(
        .DATA_WIDTH (PARAM_DATA_WIDTH),
        .DEPTH      (PARAM_FIFO_DEPTH)
    ) u_fifo (
        .clk        (i_wire_pixel_clock),
        .reset      (i_wire_reset),
        .flush      (flush_s),
        .push       (push_s),
        .push_data  (i_wire_rd_data),
        .pop        (i_wire_next_rgb),
        .head_data  (fifo_head_s),
        .count      (fifo_count_s),
        .empty      (fifo_empty_s)
    );

    assign o_wire_rgba       = 32'(fifo_head_s);
    assign o_wire_rd_req     = rd_req_r;
    assign o_wire_rd_addr    = rd_addr_r;
    assign o_wire_rd_len     = rd_len_r;
    assign o_wire_busy       = busy_r;
    assign o_wire_frame_done = frame_done_r;
    assign o_wire_dvi_resetn = dvi_resetn_r;
    assign o_wire_underflow  = underflow_r;

    // Scanout FSM: frame latching, burst request handshake, beat counting and frame end.
    always_ff @(posedge i_wire_pixel_clock) begin
        if (i_wire_reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= 32'd0;
            remaining_r  <= 32'd0;
            beats_left_r <= 8'd0;
            rd_req_r     <= 1'b0;
            rd_addr_r    <= 32'd0;
            rd_len_r     <= 8'd0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            dvi_resetn_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if ((state_r inside {ST_FETCH, ST_WAIT_DATA, ST_DRAIN}) && dvi_cond_s) begin
                dvi_resetn_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (i_wire_start) begin
                        addr_r      <= i_wire_base_addr;
                        remaining_r <= total_s;
                        busy_r      <= 1'b1;
                        if (total_s == 32'd0) begin
                            state_r      <= ST_DONE;
                            frame_done_r <= 1'b1;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    // Request fields are frozen from assertion until the ack cycle.
                    if (rd_req_r) begin
                        if (i_wire_rd_ack) begin
                            rd_req_r     <= 1'b0;
                            addr_r       <= addr_r + ({24'd0, rd_len_r} * PIXEL_STRIDE_BYTES);
                            remaining_r  <= remaining_r - {24'd0, rd_len_r};
                            beats_left_r <= rd_len_r;
                            state_r      <= ST_WAIT_DATA;
                        end
                    end else if (32'(free_s) >= {24'd0, len_s}) begin
                        rd_req_r  <= 1'b1;
                        rd_addr_r <= addr_r;
                        rd_len_r  <= len_s;
                    end
                end
                ST_WAIT_DATA: begin
                    if (i_wire_rd_valid) begin
                        beats_left_r <= beats_left_r - 8'd1;
                        if (beats_left_r == 8'd1) begin
                            if (remaining_r != 32'd0) begin
                                state_r <= ST_FETCH;
                            end else begin
                                state_r <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (i_wire_dvi_done) begin
                        state_r      <= ST_DONE;
                        frame_done_r <= 1'b1;
                        dvi_resetn_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    dvi_resetn_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    rd_req_r     <= 1'b0;
                    dvi_resetn_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCANOUT_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_r;
    assign o_wire_underflow_cnt = underflow_cnt_r;
`endif

    // Sticky underflow flag (and optional saturating count); cleared by reset or an accepted start.
    always_ff @(posedge i_wire_pixel_clock) begin
        if (i_wire_reset || start_ok_s) begin
            underflow_r <= 1'b0;
`ifdef SCANOUT_UNDERFLOW_CNT_EN
            underflow_cnt_r <= 16'd0;
`endif
        end else if (empty_pop_s) begin
            underflow_r <= 1'b1;
`ifdef SCANOUT_UNDERFLOW_CNT_EN
            if (underflow_cnt_r != 16'hFFFF) begin
                underflow_cnt_r <= underflow_cnt_r + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_scanout.sv
module tb_painterengine_gpu_scanout;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] clip_w;
    logic [15:0] clip_h;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        next_rgb;
    logic [31:0] rgba;
    logic        dvi_resetn;
    logic        dvi_done;
    logic        busy;
    logic        frame_done;
    logic        underflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sbq[$];

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic [31:0] base;
        bit          disturb;
        int          exp_nreq;
        logic [7:0]  exp_last_len;
        logic [31:0] exp_last_addr;
        bit          exp_dvi;
    } frame_vec_t;

    frame_vec_t vecs[5];

    painterengine_gpu_scanout dut (
        .i_wire_pixel_clock (clk),
        .i_wire_reset       (reset),
        .i_wire_start       (start),
        .i_wire_base_addr   (base_addr),
        .i_wire_clip_width  (clip_w),
        .i_wire_clip_height (clip_h),
        .o_wire_rd_req      (rd_req),
        .o_wire_rd_addr     (rd_addr),
        .o_wire_rd_len      (rd_len),
        .i_wire_rd_ack      (rd_ack),
        .i_wire_rd_valid    (rd_valid),
        .i_wire_rd_data     (rd_data),
        .i_wire_next_rgb    (next_rgb),
        .o_wire_rgba        (rgba),
        .o_wire_dvi_resetn  (dvi_resetn),
        .i_wire_dvi_done    (dvi_done),
        .o_wire_busy        (busy),
        .o_wire_frame_done  (frame_done),
        .o_wire_underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!rd_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, rd_req}, 32'd1);
    endtask

    task automatic run_frame(input frame_vec_t v, input int idx);
        int          cyc;
        int          nreq;
        int          fd;
        int          beats;
        int          pix;
        bit          dvi_seen;
        bit          done;
        logic [31:0] m_addr;
        logic [31:0] m_rem;
        logic [7:0]  e_len;
        logic [7:0]  last_len;
        logic [31:0] last_addr;
        logic [31:0] exp_px;
        cyc = 0; nreq = 0; fd = 0; beats = 0; pix = 0;
        dvi_seen = 1'b0; done = 1'b0; last_len = 8'd0; last_addr = 32'd0;
        m_addr = v.base;
        m_rem  = 32'(v.w) * 32'(v.h);
        @(negedge clk);
        start = 1'b1; base_addr = v.base; clip_w = v.w; clip_h = v.h;
        @(negedge clk);
        // Scramble the geometry inputs: the DUT must use the latched copy.
        start = 1'b0; base_addr = 32'hDEAD_0000; clip_w = 16'd999; clip_h = 16'd77;
        chk($sformatf("v%0d busy_after_start", idx), {31'd0, busy}, 32'd1);
        while (!done && cyc < 3000) begin
            if (frame_done) fd++;
            if (dvi_resetn) dvi_seen = 1'b1;
            if (fd > 0 && !busy) begin
                done = 1'b1;
            end else begin
                next_rgb = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0;
                start = (v.disturb && cyc == 1);
                if (start) begin
                    base_addr = 32'h0000_9000; clip_w = 16'd100; clip_h = 16'd100;
                end
                if (sbq.size() > 0 && dvi_resetn && $urandom_range(0, 3) != 0) begin
                    exp_px = sbq.pop_front();
                    chk($sformatf("v%0d pixel", idx), rgba, exp_px);
                    next_rgb = 1'b1;
                end
                if (beats > 0) begin
                    rd_valid = 1'b1;
                    rd_data  = {v.base[15:0], 16'(pix)};
                    sbq.push_back(rd_data);
                    pix++;
                    beats--;
                end else if (rd_req) begin
                    e_len = (m_rem < 32'd16) ? m_rem[7:0] : 8'd16;
                    chk($sformatf("v%0d req_addr", idx), rd_addr, m_addr);
                    chk($sformatf("v%0d req_len", idx), {24'd0, rd_len}, {24'd0, e_len});
                    rd_ack    = 1'b1;
                    nreq++;
                    last_len  = rd_len;
                    last_addr = rd_addr;
                    beats     = int'(rd_len);
                    m_addr    = m_addr + 32'(rd_len) * 32'd4;
                    m_rem     = m_rem - 32'(rd_len);
                end
                dvi_done = (m_rem == 32'd0) && (beats == 0) && (sbq.size() == 0);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; next_rgb = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0; dvi_done = 1'b0;
        chk($sformatf("v%0d finished_in_budget", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d frame_done_pulses", idx), 32'(fd), 32'd1);
        chk($sformatf("v%0d num_requests", idx), 32'(nreq), 32'(v.exp_nreq));
        chk($sformatf("v%0d last_len", idx), {24'd0, last_len}, {24'd0, v.exp_last_len});
        chk($sformatf("v%0d last_addr", idx), last_addr, v.exp_last_addr);
        chk($sformatf("v%0d dvi_seen", idx), {31'd0, dvi_seen}, {31'd0, v.exp_dvi});
        chk($sformatf("v%0d pixels_left", idx), 32'(sbq.size()), 32'd0);
        chk($sformatf("v%0d pixels_total", idx), 32'(pix), 32'(v.w) * 32'(v.h));
        chk($sformatf("v%0d dvi_low_after", idx), {31'd0, dvi_resetn}, 32'd0);
        chk($sformatf("v%0d no_underflow", idx), {31'd0, underflow}, 32'd0);
        chk($sformatf("v%0d rgba_zero_after", idx), rgba, 32'd0);
        sbq.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = 32'd0; clip_w = 16'd0; clip_h = 16'd0;
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = 32'd0; next_rgb = 1'b0; dvi_done = 1'b0;

        vecs[0] = '{16'd8,  16'd4, 32'h1000, 1'b0, 2, 8'd16, 32'h1040, 1'b1};
        vecs[1] = '{16'd20, 16'd1, 32'h1000, 1'b0, 2, 8'd4,  32'h1040, 1'b1};
        vecs[2] = '{16'd0,  16'd5, 32'h3000, 1'b0, 0, 8'd0,  32'h0,    1'b0};
        vecs[3] = '{16'd3,  16'd1, 32'h2000, 1'b1, 1, 8'd3,  32'h2000, 1'b1};
        vecs[4] = '{16'd5,  16'd7, 32'h4000, 1'b0, 3, 8'd3,  32'h4080, 1'b1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst busy",       {31'd0, busy},       32'd0);
        chk("rst frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst rd_req",     {31'd0, rd_req},     32'd0);
        chk("rst rd_addr",    rd_addr,             32'd0);
        chk("rst rd_len",     {24'd0, rd_len},     32'd0);
        chk("rst rgba",       rgba,                32'd0);
        chk("rst dvi_resetn", {31'd0, dvi_resetn}, 32'd0);
        chk("rst underflow",  {31'd0, underflow},  32'd0);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], i);
        end

        // Request held without ack; then a pop on an empty FIFO.
        @(negedge clk);
        start = 1'b1; base_addr = 32'h1000; clip_w = 16'd8; clip_h = 16'd4;
        @(negedge clk);
        start = 1'b0;
        wait_req("hold req_seen");
        chk("hold first_addr", rd_addr, 32'h1000);
        chk("hold first_len", {24'd0, rd_len}, 32'd16);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold req_stable", {31'd0, rd_req}, 32'd1);
            chk("hold addr_stable", rd_addr, 32'h1000);
            chk("hold len_stable", {24'd0, rd_len}, 32'd16);
        end
        next_rgb = 1'b1;
        @(negedge clk);
        next_rgb = 1'b0;
        chk("empty_pop underflow", {31'd0, underflow}, 32'd1);
        chk("empty_pop rgba", rgba, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("hold_rst underflow_cleared", {31'd0, underflow}, 32'd0);
        chk("hold_rst busy", {31'd0, busy}, 32'd0);
        chk("hold_rst rd_req", {31'd0, rd_req}, 32'd0);

        // Reset landing on the 5th beat of the second burst.
        @(negedge clk);
        start = 1'b1; base_addr = 32'h1000; clip_w = 16'd8; clip_h = 16'd4;
        @(negedge clk);
        start = 1'b0;
        wait_req("midrst req1_seen");
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_valid = 1'b1; rd_data = 32'hA000_0000 + 32'(i);
            @(negedge clk);
        end
        rd_valid = 1'b0;
        wait_req("midrst req2_seen");
        chk("midrst req2_addr", rd_addr, 32'h1040);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1; rd_data = 32'hB000_0000 + 32'(i);
            @(negedge clk);
        end
        chk("midrst dvi_high_before", {31'd0, dvi_resetn}, 32'd1);
        rd_valid = 1'b1; rd_data = 32'hB000_0004; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst rgba_empty", rgba, 32'd0);
        chk("midrst rd_req", {31'd0, rd_req}, 32'd0);
        chk("midrst dvi_resetn", {31'd0, dvi_resetn}, 32'd0);
        for (int i = 5; i < 16; i++) begin
            rd_valid = 1'b1; rd_data = 32'hB000_0000 + 32'(i);
            @(negedge clk);
        end
        rd_valid = 1'b0;
        chk("midrst late_beats_dropped", rgba, 32'd0);
        chk("midrst still_idle", {31'd0, busy}, 32'd0);
        next_rgb = 1'b1;
        @(negedge clk);
        next_rgb = 1'b0;
        chk("midrst fifo_was_empty", {31'd0, underflow}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
